count_bits: RTL and testbench
=============================

// Module: count_bits
// PURPOSE
//   Registered population counter: reports how many bits of the BIT_WIDTH-wide
//   input word are set. Used by the timestamped channel packer (util_cpack2
//   path) to turn a channel-enable mask into an active-channel count.
//   Carries a valid flag alongside the data; the block has no backpressure.
// PARAMETERS
//   BIT_WIDTH    4   width of input word, >= 1
//   COUNT_WIDTH  localparam = $clog2(BIT_WIDTH+1); width of count (3 for BIT_WIDTH=4)
// PORTS
//   clk          in   1            clock, all logic on rising edge
//   resetn       in   1            reset, asynchronous, active-low
//   bits_valid   in   1            bits is valid this cycle
//   bits         in   BIT_WIDTH    word to count
//   count_valid  out  1            count is valid
//   count        out  COUNT_WIDTH  number of '1' bits in the sampled word
//   count_zero   out  1            count == 0; qualified by count_valid
//   count_full   out  1            count == BIT_WIDTH; qualified by count_valid
// BEHAVIOUR
//   - Reset: resetn low forces count=0, count_valid=0, count_zero=1, count_full=0
//     immediately (async assert). Release is synchronous to clk. Pipeline
//     contents are discarded when reset asserts mid-operation.
//   - Every rising edge samples bits and bits_valid. There is no stall.
//     Back-to-back valid words give one result per cycle.
//   - Latency is 1 cycle without the optional feature and 2 cycles with it.
//     bits_valid is delayed by the same number of cycles as count.
//   - The count data path updates every cycle whether or not bits_valid is set.
//     Results taken while bits_valid=0 are don't-care for consumers, but they
//     must still be well-defined: no X after reset.
//   - Arithmetic:
//     - Compute the count as an unsigned adder tree over the input bits.
//       Intermediate sums are zero-extended to COUNT_WIDTH.
//     - Overflow is impossible because the maximum count is BIT_WIDTH.
//     - Leaf width is 1 bit; each tree level adds pairs. For an odd element
//       count, the last element passes through unchanged.
//   - Edge cases:
//     - BIT_WIDTH=1: count equals bits[0], width 1.
//     - All-zero input: count=0, count_zero=1.
//     - All-ones input: count=BIT_WIDTH, count_full=1.
//   - count_zero and count_full are registered from the same stage as count.
//     They must never disagree with count in any cycle.
//   - Outputs hold their last value while bits is unchanged. No glitches
//     appear at the outputs because they are registered.
// CONFIGURATION
//   - COUNT_BITS_PIPE_EN defined:
//     - Insert a register after the first half of the adder tree:
//       ceil(levels/2) levels in stage 1, the rest in stage 2.
//     - Latency is 2 cycles; throughput stays one word per cycle.
//     - The extra stage resets to zero, with valid=0.
//   - COUNT_BITS_PIPE_EN undefined: the whole tree is combinational before a
//     single output register; latency is 1 cycle.
// TESTING (BIT_WIDTH=4, check after stated latency L=1 or 2)
//   1. Hold resetn=0 and drive bits=4'hF with bits_valid=1.
//      -> count=0, count_valid=0, count_zero=1 throughout.
//   2. Sweep bits 0..15, one per cycle, with bits_valid=1.
//      -> count = 0,1,1,2,1,2,2,3,1,2,2,3,2,3,3,4 and count_valid=1 stream,
//         delayed by L.
//   3. Drive bits=4'h0, then 4'hF.
//      -> count_zero=1 with count=0, then count_full=1 with count=4.
//   4. Toggle bits_valid 1,0,1,0 while driving bits=4'h5.
//      -> count_valid = 1,0,1,0 delayed by L; count=2 on the valid cycles.
//   5. Assert resetn low mid-stream, between clock edges.
//      -> outputs clear at once without waiting for clk. The first result after
//         release appears L cycles after the first sampled valid word.
//   6. Re-run scenarios 2 and 4 with BIT_WIDTH=1 and BIT_WIDTH=7.
//      -> count matches $countones(bits) in every valid cycle.

Source files
------------

// File: rtl/count_bits.sv
// Registered population counter with a valid flag; one result per clock, no stall.
// Define COUNT_BITS_PIPE_EN to split the adder tree over two register stages.
module count_bits #(
   parameter  int BIT_WIDTH   = 4,
   localparam int COUNT_WIDTH = $clog2(BIT_WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   bits_valid,
   input  logic [BIT_WIDTH-1:0]   bits,
   output logic                   count_valid,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   count_zero,
   output logic                   count_full
);

   localparam int CW     = COUNT_WIDTH;
   localparam int VW     = BIT_WIDTH * CW;
   localparam int LEVELS = $clog2(BIT_WIDTH);

   // Run n_lev pairwise-add levels over n_in CW-wide elements packed in v_in.
   // An odd trailing element passes through; vacated slots read as zero.
   function automatic logic [VW-1:0] tree_reduce(input logic [VW-1:0] v_in,
                                                 input int n_in, input int n_lev);
      logic [2*VW-1:0] cur;
      logic [2*VW-1:0] nxt;
      int              n;
      cur = '0;
      cur[VW-1:0] = v_in;
      n = n_in;
      for (int l = 0; l < n_lev; l++) begin
         nxt = '0;
         for (int i = 0; i < BIT_WIDTH; i++) begin
            if (2*i + 1 < n) begin
               nxt[i*CW +: CW] = cur[2*i*CW +: CW] + cur[(2*i+1)*CW +: CW];
            end else if (2*i < n) begin
               nxt[i*CW +: CW] = cur[2*i*CW +: CW];
            end else begin
               nxt[i*CW +: CW] = '0;
            end
         end
         cur = nxt;
         n = (n + 1) / 2;
      end
      return cur[VW-1:0];
   endfunction

   function automatic logic [CW-1:0] tree_total(input logic [VW-1:0] v_in,
                                                input int n_in, input int n_lev);
      logic [VW-1:0] r;
      r = tree_reduce(v_in, n_in, n_lev);
      return r[CW-1:0];
   endfunction

   logic [VW-1:0] leaf_s;
   logic [CW-1:0] sum_s;
   logic          valid_s;
   logic [CW-1:0] count_d, count_q;
   logic          count_valid_d, count_valid_q;
   logic          count_zero_d, count_zero_q;
   logic          count_full_d, count_full_q;

   // Zero-extend each input bit into its own leaf element
   always_comb begin
      leaf_s = '0;
      for (int i = 0; i < BIT_WIDTH; i++) begin
         leaf_s[i*CW +: CW] = CW'(bits[i]);
      end
   end

`ifdef COUNT_BITS_PIPE_EN
   localparam int S1_LEVELS = (LEVELS + 1) / 2;
   localparam int N_S1      = (BIT_WIDTH + (1 << S1_LEVELS) - 1) >> S1_LEVELS;

   logic [VW-1:0] mid_d, mid_q;
   logic          mid_valid_d, mid_valid_q;

   // First half of the adder tree, feeding the mid-tree register
   always_comb begin
      mid_d       = tree_reduce(leaf_s, BIT_WIDTH, S1_LEVELS);
      mid_valid_d = bits_valid;
   end

   // Mid-tree pipeline register; cleared to zero partial sums, not valid
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mid_q       <= '0;
         mid_valid_q <= 1'b0;
      end else begin
         mid_q       <= mid_d;
         mid_valid_q <= mid_valid_d;
      end
   end

   // Remaining tree levels from the registered partial sums
   always_comb begin
      sum_s   = tree_total(mid_q, N_S1, LEVELS - S1_LEVELS);
      valid_s = mid_valid_q;
   end
`else
   // Whole tree ahead of the single output register
   always_comb begin
      sum_s   = tree_total(leaf_s, BIT_WIDTH, LEVELS);
      valid_s = bits_valid;
   end
`endif

   // Zero/full flags come from the same sum so they always agree with count
   always_comb begin
      count_d       = sum_s;
      count_valid_d = valid_s;
      count_zero_d  = (sum_s == CW'(0));
      count_full_d  = (sum_s == CW'(BIT_WIDTH));
   end

   // Output register stage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q       <= '0;
         count_valid_q <= 1'b0;
         count_zero_q  <= 1'b1;
         count_full_q  <= 1'b0;
      end else begin
         count_q       <= count_d;
         count_valid_q <= count_valid_d;
         count_zero_q  <= count_zero_d;
         count_full_q  <= count_full_d;
      end
   end

   assign count       = count_q;
   assign count_valid = count_valid_q;
   assign count_zero  = count_zero_q;
   assign count_full  = count_full_q;

endmodule

// File: tb/tb_count_bits.sv
// Self-checking bench for count_bits: widths 4, 1 and 7 driven side by side,
// expected results queued at drive time and compared when they emerge.
module tb_count_bits;

`ifdef COUNT_BITS_PIPE_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic       clk;
   logic       resetn;
   logic       valid;
   logic [3:0] bits4;
   logic [0:0] bits1;
   logic [6:0] bits7;
   logic       cv4, cz4, cf4, cv1, cz1, cf1, cv7, cz7, cf7;
   logic [2:0] c4;
   logic [0:0] c1;
   logic [2:0] c7;

   int n_vec;
   int n_err;

   typedef struct {
      logic       v;
      logic [2:0] c4;
      logic [0:0] c1;
      logic [2:0] c7;
   } exp_t;

   typedef struct {
      logic [3:0] bits;
      logic       valid;
      logic [2:0] exp;
   } vec_t;

   exp_t q[$];
   vec_t tbl[$];

   count_bits #(.BIT_WIDTH(4)) u_dut4 (
      .clk(clk), .resetn(resetn), .bits_valid(valid), .bits(bits4),
      .count_valid(cv4), .count(c4), .count_zero(cz4), .count_full(cf4));
   count_bits #(.BIT_WIDTH(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .bits_valid(valid), .bits(bits1),
      .count_valid(cv1), .count(c1), .count_zero(cz1), .count_full(cf1));
   count_bits #(.BIT_WIDTH(7)) u_dut7 (
      .clk(clk), .resetn(resetn), .bits_valid(valid), .bits(bits7),
      .count_valid(cv7), .count(c7), .count_zero(cz7), .count_full(cf7));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk("valid4", int'(cv4), int'(e.v));
      chk("count4", int'(c4), int'(e.c4));
      chk("zero4",  int'(cz4), int'(e.c4 == 3'd0));
      chk("full4",  int'(cf4), int'(e.c4 == 3'd4));
      chk("valid1", int'(cv1), int'(e.v));
      chk("count1", int'(c1), int'(e.c1));
      chk("zero1",  int'(cz1), int'(e.c1 == 1'b0));
      chk("full1",  int'(cf1), int'(e.c1 == 1'b1));
      chk("valid7", int'(cv7), int'(e.v));
      chk("count7", int'(c7), int'(e.c7));
      chk("zero7",  int'(cz7), int'(e.c7 == 3'd0));
      chk("full7",  int'(cf7), int'(e.c7 == 3'd7));
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.v = 1'b0; e.c4 = 3'd0; e.c1 = 1'b0; e.c7 = 3'd0;
      return e;
   endfunction

   // The mid-tree register (when present) holds reset zeros for L-1 results
   task automatic restart_queue();
      q.delete();
      for (int i = 0; i < L - 1; i++) q.push_back(reset_exp());
   endtask

   task automatic step(input logic [3:0] b4, input logic [2:0] e4, input logic v,
                       input logic [6:0] b7);
      exp_t e;
      bits4 = b4;
      bits1 = b4[0];
      bits7 = b7;
      valid = v;
      e.v  = v;
      e.c4 = e4;
      e.c1 = b4[0];
      e.c7 = 3'($countones(b7));
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() >= L) chk_all(q.pop_front());
   endtask

   function automatic logic [6:0] pick7(input logic [3:0] b4);
      if (b4 == 4'hF) return 7'h7F;
      else if (b4 == 4'h0) return 7'h00;
      else return 7'($urandom_range(0, 127));
   endfunction

   initial begin
      logic [2:0] sweep_exp [16];
      vec_t       vt;
      n_vec = 0;
      n_err = 0;
      sweep_exp = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                    3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};
      for (int i = 0; i < 16; i++) begin
         vt.bits = 4'(i); vt.valid = 1'b1; vt.exp = sweep_exp[i];
         tbl.push_back(vt);
      end
      vt.bits = 4'h0; vt.valid = 1'b1; vt.exp = 3'd0; tbl.push_back(vt);
      vt.bits = 4'hF; vt.valid = 1'b1; vt.exp = 3'd4; tbl.push_back(vt);
      for (int i = 0; i < 4; i++) begin
         vt.bits = 4'h5; vt.valid = (i % 2 == 0); vt.exp = 3'd2; tbl.push_back(vt);
      end
      vt.bits = 4'hF; vt.valid = 1'b0; vt.exp = 3'd4; tbl.push_back(vt);
      vt.bits = 4'hF; vt.valid = 1'b1; vt.exp = 3'd4; tbl.push_back(vt);

      // Held in reset with an all-ones valid word on the inputs
      resetn = 1'b0;
      valid  = 1'b1;
      bits4  = 4'hF;
      bits1  = 1'b1;
      bits7  = 7'h7F;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_all(reset_exp());
      end
      @(negedge clk);
      resetn = 1'b1;
      restart_queue();

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].bits, tbl[i].exp, tbl[i].valid, pick7(tbl[i].bits));
      end
      for (int i = 0; i < 10; i++) begin
         logic [3:0] b;
         b = 4'($urandom_range(0, 15));
         step(b, 3'($countones(b)), 1'($urandom_range(0, 1)), pick7(b));
      end

      // Mid-stream reset between edges: outputs clear without a clock edge
      step(4'hF, 3'd4, 1'b1, 7'h7F);
      step(4'hF, 3'd4, 1'b1, 7'h7F);
      #2;
      resetn = 1'b0;
      #1;
      chk_all(reset_exp());
      q.delete();
      @(negedge clk);
      resetn = 1'b1;
      restart_queue();
      step(4'h6, 3'd2, 1'b1, 7'h15);
      step(4'hB, 3'd3, 1'b1, 7'h40);
      step(4'h8, 3'd1, 1'b0, 7'h7E);
      for (int i = 0; i < L; i++) step(4'h0, 3'd0, 1'b0, 7'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
